// File: rtl/buffer_arbiter_if.sv
// Bus bundle between the buffer arbiter and its clients (USB RX/TX engines, AHB slave).
// Carries requests, byte strobes and flush from the clients, and grants and status back to them.
interface buffer_arbiter_if #(
    parameter int OCC_W = 7
);
    // Handshake: a side holds x_req high for as long as it wants the buffer. Ownership
    // starts on the cycle after x_gnt rises and ends when x_done pulses or x_req drops.
    // push/pop are one-byte strobes from whichever side currently owns the buffer.
    logic             usb_req;
    logic             usb_done;
    logic             ahb_req;
    logic             ahb_done;
    logic             push;
    logic             pop;
    logic             clear;
    logic             usb_gnt;
    logic             ahb_gnt;
    logic             buffer_reserved;
    logic [OCC_W-1:0] buffer_occupancy;
    logic             overflow_err;
    logic             underflow_err;
    logic             hold_timeout;
    logic [1:0]       state_dbg;

    modport master (
        output usb_req, usb_done, ahb_req, ahb_done, push, pop, clear,
        input  usb_gnt, ahb_gnt, buffer_reserved, buffer_occupancy,
               overflow_err, underflow_err, hold_timeout, state_dbg
    );

    modport slave (
        input  usb_req, usb_done, ahb_req, ahb_done, push, pop, clear,
        output usb_gnt, ahb_gnt, buffer_reserved, buffer_occupancy,
               overflow_err, underflow_err, hold_timeout, state_dbg
    );
endinterface

// File: rtl/buffer_arbiter.sv
// Exclusive-ownership arbiter and occupancy counter for the shared 64-byte endpoint buffer.
// Optional grant watchdog enabled by defining BUFFER_ARB_TIMEOUT_EN.
module buffer_arbiter #(
    parameter int DEPTH    = 64,
    parameter int OCC_W    = 7,
    parameter int MAX_HOLD = 255
) (
    input logic                clk,
    input logic                n_rst,
    buffer_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_USB  = 2'd1,
        GRANT_AHB  = 2'd2,
        TURNAROUND = 2'd3
    } state_t;

    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    state_t           state;
    logic             last_usb;
    logic             usb_gnt;
    logic             ahb_gnt;
    logic             reserved;
    logic             hold_timeout;
    logic [OCC_W-1:0] occ;
    logic             overflow_err;
    logic             underflow_err;

    logic usb_release;
    logic ahb_release;
    logic hold_expire;

    assign usb_release = bus.usb_done || !bus.usb_req;
    assign ahb_release = bus.ahb_done || !bus.ahb_req;

`ifdef BUFFER_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    // Fires on the grant cycle whose count reaches MAX_HOLD, so gnt stays high MAX_HOLD cycles.
    assign hold_expire = (hold_cnt == 8'(MAX_HOLD - 1));
`else
    assign hold_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            last_usb     <= 1'b0;
            usb_gnt      <= 1'b0;
            ahb_gnt      <= 1'b0;
            reserved     <= 1'b0;
            hold_timeout <= 1'b0;
`ifdef BUFFER_ARB_TIMEOUT_EN
            hold_cnt     <= 8'd0;
`endif
        end else begin
            hold_timeout <= 1'b0;
            case (state)
                IDLE: begin
`ifdef BUFFER_ARB_TIMEOUT_EN
                    hold_cnt <= 8'd0;
`endif
                    // On a tie the side that did not own the buffer last goes first.
                    if (bus.usb_req && (!bus.ahb_req || !last_usb)) begin
                        state    <= GRANT_USB;
                        usb_gnt  <= 1'b1;
                        reserved <= 1'b1;
                        last_usb <= 1'b1;
                    end else if (bus.ahb_req) begin
                        state    <= GRANT_AHB;
                        ahb_gnt  <= 1'b1;
                        reserved <= 1'b1;
                        last_usb <= 1'b0;
                    end
                end
                GRANT_USB: begin
`ifdef BUFFER_ARB_TIMEOUT_EN
                    hold_cnt <= hold_cnt + 8'd1;
`endif
                    if (usb_release || hold_expire) begin
                        state        <= TURNAROUND;
                        usb_gnt      <= 1'b0;
                        hold_timeout <= hold_expire && !usb_release;
                    end
                end
                GRANT_AHB: begin
`ifdef BUFFER_ARB_TIMEOUT_EN
                    hold_cnt <= hold_cnt + 8'd1;
`endif
                    if (ahb_release || hold_expire) begin
                        state        <= TURNAROUND;
                        ahb_gnt      <= 1'b0;
                        hold_timeout <= hold_expire && !ahb_release;
                    end
                end
                TURNAROUND: begin
                    state    <= IDLE;
                    reserved <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    usb_gnt  <= 1'b0;
                    ahb_gnt  <= 1'b0;
                    reserved <= 1'b0;
                end
            endcase
        end
    end

    logic grant_active;
    logic push_only;
    logic pop_only;

    // Strobes count against the registered grant, i.e. only while a side actually owns the buffer.
    assign grant_active = usb_gnt || ahb_gnt;
    assign push_only    = grant_active && bus.push && !bus.pop;
    assign pop_only     = grant_active && bus.pop && !bus.push;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            occ           <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            if (bus.clear) begin
                occ <= '0;
            end else if (push_only) begin
                if (occ >= FULL) overflow_err <= 1'b1;
                else             occ <= occ + 1'b1;
            end else if (pop_only) begin
                if (occ == '0) underflow_err <= 1'b1;
                else           occ <= occ - 1'b1;
            end
        end
    end

    assign bus.usb_gnt          = usb_gnt;
    assign bus.ahb_gnt          = ahb_gnt;
    assign bus.buffer_reserved  = reserved;
    assign bus.buffer_occupancy = occ;
    assign bus.overflow_err     = overflow_err;
    assign bus.underflow_err    = underflow_err;
    assign bus.hold_timeout     = hold_timeout;
    assign bus.state_dbg        = state;
endmodule

// File: tb/tb_buffer_arbiter.sv
// Directed bench for buffer_arbiter: a vector table for arbitration and occupancy, plus
// hand sequences for tie latency, fill/overflow, clear, async reset and the grant watchdog.
module tb_buffer_arbiter;
    localparam int OCC_W = 7;
    localparam int MAX_HOLD_TB = 8;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TURN = 2'd3;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    buffer_arbiter_if #(.OCC_W(OCC_W)) bus ();

    buffer_arbiter #(
        .DEPTH(64),
        .OCC_W(OCC_W),
        .MAX_HOLD(MAX_HOLD_TB)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // in  = {usb_req, usb_done, ahb_req, ahb_done, push, pop, clear}
    // gnt = {usb_gnt, ahb_gnt, buffer_reserved}; err = {overflow_err, underflow_err}
    typedef struct {
        logic [6:0]       in;
        logic [2:0]       gnt;
        logic [OCC_W-1:0] occ;
        logic [1:0]       err;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic [6:0] in);
        {bus.usb_req, bus.usb_done, bus.ahb_req, bus.ahb_done, bus.push, bus.pop, bus.clear} = in;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("gnt_onehot", {31'd0, bus.usb_gnt & bus.ahb_gnt}, 32'd0);
    endtask

    task automatic do_reset();
        drive(7'b0);
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{7'b0000000, 3'b000, 7'd0, 2'b00};
        vecs[1]  = '{7'b0000100, 3'b000, 7'd0, 2'b00};
        vecs[2]  = '{7'b0010100, 3'b011, 7'd0, 2'b00};
        vecs[3]  = '{7'b0010010, 3'b011, 7'd0, 2'b01};
        vecs[4]  = '{7'b0010100, 3'b011, 7'd1, 2'b00};
        vecs[5]  = '{7'b0010100, 3'b011, 7'd2, 2'b00};
        vecs[6]  = '{7'b0010110, 3'b011, 7'd2, 2'b00};
        vecs[7]  = '{7'b0010010, 3'b011, 7'd1, 2'b00};
        vecs[8]  = '{7'b0010101, 3'b011, 7'd0, 2'b00};
        vecs[9]  = '{7'b1010100, 3'b011, 7'd1, 2'b00};
        vecs[10] = '{7'b1011000, 3'b001, 7'd1, 2'b00};
        vecs[11] = '{7'b1010000, 3'b000, 7'd1, 2'b00};
        vecs[12] = '{7'b1010100, 3'b101, 7'd1, 2'b00};
        vecs[13] = '{7'b0010100, 3'b001, 7'd2, 2'b00};
        vecs[14] = '{7'b0010100, 3'b000, 7'd2, 2'b00};
        vecs[15] = '{7'b0010000, 3'b011, 7'd2, 2'b00};
        vecs[16] = '{7'b0000000, 3'b001, 7'd2, 2'b00};
        vecs[17] = '{7'b0000001, 3'b000, 7'd0, 2'b00};

        // Reset state
        do_reset();
        check("rst_usb_gnt", {31'd0, bus.usb_gnt}, 32'd0);
        check("rst_ahb_gnt", {31'd0, bus.ahb_gnt}, 32'd0);
        check("rst_reserved", {31'd0, bus.buffer_reserved}, 32'd0);
        check("rst_occ", {25'd0, bus.buffer_occupancy}, 32'd0);
        check("rst_errs", {29'd0, bus.overflow_err, bus.underflow_err, bus.hold_timeout}, 32'd0);
        check("rst_state", {30'd0, bus.state_dbg}, {30'd0, ST_IDLE});

        // Vector table
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].in);
            tick();
            check($sformatf("v%0d_gnt", i), {29'd0, bus.usb_gnt, bus.ahb_gnt, bus.buffer_reserved},
                  {29'd0, vecs[i].gnt});
            check($sformatf("v%0d_occ", i), {25'd0, bus.buffer_occupancy}, {25'd0, vecs[i].occ});
            check($sformatf("v%0d_err", i), {30'd0, bus.overflow_err, bus.underflow_err},
                  {30'd0, vecs[i].err});
            check($sformatf("v%0d_hto", i), {31'd0, bus.hold_timeout}, 32'd0);
        end

        // Tie after reset goes to USB; AHB granted three cycles after usb_done
        do_reset();
        drive(7'b1010000);
        tick();
        check("tie_usb_gnt", {31'd0, bus.usb_gnt}, 32'd1);
        check("tie_ahb_gnt", {31'd0, bus.ahb_gnt}, 32'd0);
        drive(7'b1110000);
        tick();
        check("done_usb_gnt", {31'd0, bus.usb_gnt}, 32'd0);
        check("done_turn", {30'd0, bus.state_dbg}, {30'd0, ST_TURN});
        check("done_reserved", {31'd0, bus.buffer_reserved}, 32'd1);
        drive(7'b1010000);
        tick();
        check("idle_reserved", {31'd0, bus.buffer_reserved}, 32'd0);
        check("idle_no_gnt", {30'd0, bus.usb_gnt, bus.ahb_gnt}, 32'd0);
        tick();
        check("regrant_ahb", {31'd0, bus.ahb_gnt}, 32'd1);
        check("regrant_usb", {31'd0, bus.usb_gnt}, 32'd0);
        drive(7'b0);
        tick();
        tick();

        // Fill to 64, overflow, push+pop at full, drain to 37, clear+push, underflow
        drive(7'b0010000);
        tick();
        check("fill_gnt", {31'd0, bus.ahb_gnt}, 32'd1);
        drive(7'b0010100);
        repeat (64) tick();
        check("fill_occ64", {25'd0, bus.buffer_occupancy}, 32'd64);
        check("fill_no_ovf", {31'd0, bus.overflow_err}, 32'd0);
        tick();
        check("ovf_occ", {25'd0, bus.buffer_occupancy}, 32'd64);
        check("ovf_pulse", {31'd0, bus.overflow_err}, 32'd1);
        drive(7'b0010000);
        tick();
        check("ovf_pulse_end", {31'd0, bus.overflow_err}, 32'd0);
        drive(7'b0010110);
        tick();
        check("pushpop_full_occ", {25'd0, bus.buffer_occupancy}, 32'd64);
        check("pushpop_full_err", {30'd0, bus.overflow_err, bus.underflow_err}, 32'd0);
        drive(7'b0010010);
        repeat (27) tick();
        check("drain_occ37", {25'd0, bus.buffer_occupancy}, 32'd37);
        drive(7'b0010101);
        tick();
        check("clear_occ", {25'd0, bus.buffer_occupancy}, 32'd0);
        check("clear_gnt", {31'd0, bus.ahb_gnt}, 32'd1);
        check("clear_err", {30'd0, bus.overflow_err, bus.underflow_err}, 32'd0);
        drive(7'b0010010);
        tick();
        check("unf_pulse", {31'd0, bus.underflow_err}, 32'd1);
        check("unf_occ", {25'd0, bus.buffer_occupancy}, 32'd0);
        drive(7'b0010000);
        tick();
        check("unf_pulse_end", {31'd0, bus.underflow_err}, 32'd0);
        drive(7'b0);
        tick();
        tick();

        // Asynchronous reset while USB holds the buffer with data in it
        drive(7'b1000000);
        tick();
        drive(7'b1000100);
        repeat (3) tick();
        check("pre_rst_occ", {25'd0, bus.buffer_occupancy}, 32'd3);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_usb_gnt", {31'd0, bus.usb_gnt}, 32'd0);
        check("arst_reserved", {31'd0, bus.buffer_reserved}, 32'd0);
        check("arst_occ", {25'd0, bus.buffer_occupancy}, 32'd0);
        drive(7'b0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        check("arst_idle", {30'd0, bus.state_dbg}, {30'd0, ST_IDLE});
        check("arst_no_gnt", {30'd0, bus.usb_gnt, bus.ahb_gnt}, 32'd0);

        // Grant watchdog
        do_reset();
        drive(7'b1010000);
        tick();
        check("hold_gnt_start", {31'd0, bus.usb_gnt}, 32'd1);
`ifdef BUFFER_ARB_TIMEOUT_EN
        repeat (MAX_HOLD_TB - 1) begin
            tick();
            check("hold_gnt_held", {31'd0, bus.usb_gnt}, 32'd1);
            check("hold_no_pulse", {31'd0, bus.hold_timeout}, 32'd0);
        end
        tick();
        check("hto_gnt_drop", {31'd0, bus.usb_gnt}, 32'd0);
        check("hto_pulse", {31'd0, bus.hold_timeout}, 32'd1);
        tick();
        check("hto_pulse_end", {31'd0, bus.hold_timeout}, 32'd0);
        tick();
        check("hto_ahb_wins", {31'd0, bus.ahb_gnt}, 32'd1);
`else
        repeat (3 * MAX_HOLD_TB) begin
            tick();
            check("hold_gnt_held", {31'd0, bus.usb_gnt}, 32'd1);
            check("hold_no_pulse", {31'd0, bus.hold_timeout}, 32'd0);
        end
`endif
        drive(7'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
